// File: rtl/rca4_nibble_sequencer_if.sv
// Request/response bundle for rca4_nibble_sequencer.
//   master : client side (drives operands, accepts results)
//   slave  : sequencer side (accepts operands, returns results)
// Signals:
//   req_valid/req_ready  operand handshake
//   req_a/req_b/req_ci   operands and carry-in
//   rsp_valid/rsp_ready  result handshake
//   rsp_sum/rsp_co/rsp_ovf  sum, carry-out, two's-complement overflow
interface rca4_nibble_sequencer_if #(
   parameter int unsigned WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_ci;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_co;
   logic             rsp_ovf;

   modport master (
      output req_valid, req_a, req_b, req_ci, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ovf
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ci, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ovf
   );
endinterface

// File: rtl/rca4_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder controller driving one external 4-bit ripple-carry adder.
// Operands are taken over a valid/ready request port, added one nibble per cycle LSB first
// with the carry chained through a register, and returned over a valid/ready response port.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus (slave)      request/response handshake bundle
//   busy             high whenever not idle
//   rca_a/b/ci       nibble operands and carry to the external rca4
//   rca_s/co         combinational sum/carry back from the rca4
module rca4_nibble_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   rca4_nibble_sequencer_if.slave    bus,
   output logic                      busy,
   output logic [3:0]                rca_a,
   output logic [3:0]                rca_b,
   output logic                      rca_ci,
   input  logic [3:0]                rca_s,
   input  logic                      rca_co
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e           state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
   logic             rsp_co_q, rsp_co_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] sum_nxt;

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_co_d    = rsp_co_q;
      rsp_ovf_d   = rsp_ovf_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      rca_a       = 4'h0;
      rca_b       = 4'h0;
      rca_ci      = 1'b0;
      // Partial sum with the current nibble merged in; used on the final pass.
      sum_nxt                 = sum_q;
      sum_nxt[4*idx_q +: 4]   = rca_s;

      unique case (state_q)
         StIdle: begin
            // Also raises req_ready on the first edge after reset release.
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               a_d         = bus.req_a;
               b_d         = bus.req_b;
               carry_d     = bus.req_ci;
               idx_d       = '0;
               req_ready_d = 1'b0;
               state_d     = StAdd;
            end
         end
         StAdd: begin
            rca_a   = a_q[4*idx_q +: 4];
            rca_b   = b_q[4*idx_q +: 4];
            rca_ci  = carry_q;
            sum_d   = sum_nxt;
            carry_d = rca_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
               idx_d       = '0;
               rsp_sum_d   = sum_nxt;
               rsp_co_d    = rca_co;
               rsp_ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (sum_nxt[WIDTH-1] != a_q[WIDTH-1]);
               rsp_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_co_q    <= 1'b0;
         rsp_ovf_q   <= 1'b0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_co_q    <= rsp_co_d;
         rsp_ovf_q   <= rsp_ovf_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_co    = rsp_co_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_rca4_nibble_sequencer.sv
// Bench for rca4_nibble_sequencer (WIDTH=16) with a behavioural rca4 and reference model.
module tb_rca4_nibble_sequencer;
   localparam int unsigned W = 16;
   localparam int unsigned N = W / 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       busy;
   logic [3:0] rca_a, rca_b, rca_s;
   logic       rca_ci, rca_co;

   rca4_nibble_sequencer_if #(.WIDTH(W)) bus ();

   rca4_nibble_sequencer #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .busy   (busy),
      .rca_a  (rca_a),
      .rca_b  (rca_b),
      .rca_ci (rca_ci),
      .rca_s  (rca_s),
      .rca_co (rca_co)
   );

   // External 4-bit adder.
   assign {rca_co, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0, rca_ci};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0;
   int errs = 0;
   bit tie_ready = 1'b0;
   logic [3:0] ci_seq;
   int lat;
   int acc_cyc;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] sum;
      logic        co;
      logic        ovf;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: whole-word arithmetic.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci);
      logic [16:0] full;
      logic        ovf;
      full = {1'b0, a} + {1'b0, b} + {16'b0, ci};
      ovf  = (a[15] == b[15]) && (full[15] != a[15]);
      return {ovf, full[16], full[15:0]};
   endfunction

   // Carry entering nibble k of a+b+ci.
   function automatic logic cin_nib(input logic [15:0] a, input logic [15:0] b,
                                    input logic ci, input int k);
      int unsigned m, t;
      if (k == 0) return ci;
      m = (32'd1 << (4 * k)) - 1;
      t = (a & m) + (b & m) + ci;
      return t[4*k];
   endfunction

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_ci    = ci;
      while (!bus.req_ready && n < 50) begin
         step();
         n++;
      end
      if (!bus.req_ready) check("req_ready_timeout", 0, 1);
      step();
      acc_cyc       = cyc;
      bus.req_valid = 1'b0;
      lat           = 0;
      ci_seq        = '0;
      while (!bus.rsp_valid && lat < 50) begin
         if (lat < N) ci_seq[lat] = rca_ci;
         step();
         lat++;
      end
      if (!bus.rsp_valid) check("rsp_valid_timeout", 0, 1);
   endtask

   task automatic ack();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = tie_ready;
   endtask

   task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic ci);
      logic [17:0] e;
      e = model(a, b, ci);
      check({tag, "_sum"}, bus.rsp_sum, e[15:0]);
      check({tag, "_co"}, bus.rsp_co, e[16]);
      check({tag, "_ovf"}, bus.rsp_ovf, e[17]);
      check({tag, "_latency"}, lat, N);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [17:0] e;
      logic [15:0] held;
      logic [15:0] ra, rb;
      logic        rc;
      int          prev;
      int          saw;

      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_ci    = 1'b0;
      bus.rsp_ready = 1'b0;

      // Reset state.
      #2 rst_n = 1'b0;
      #1;
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_sum", bus.rsp_sum, 0);
      check("rst_busy", busy, 0);
      check("rst_rca", {rca_a, rca_b, rca_ci}, 0);
      step();
      step();
      rst_n = 1'b1;
      check("req_ready_before_edge", bus.req_ready, 0);
      step();
      check("req_ready_after_edge", bus.req_ready, 1);

      // Directed vectors.
      for (int i = 0; i < 7; i++) begin
         issue(tbl[i].a, tbl[i].b, tbl[i].ci);
         check("tbl_sum", bus.rsp_sum, tbl[i].sum);
         check("tbl_co", bus.rsp_co, tbl[i].co);
         check("tbl_ovf", bus.rsp_ovf, tbl[i].ovf);
         check("tbl_latency", lat, N);
         for (int k = 0; k < N; k++)
            check("tbl_rca_ci", ci_seq[k], cin_nib(tbl[i].a, tbl[i].b, tbl[i].ci, k));
         if (i == 1) check("ffff_rca_ci_seq", ci_seq, 4'b1110);
         ack();
         check("tbl_rsp_valid_drop", bus.rsp_valid, 0);
         check("tbl_req_ready_back", bus.req_ready, 1);
         check("tbl_sum_held", bus.rsp_sum, tbl[i].sum);
      end

      // Response backpressure with a pending request.
      issue(16'h1111, 16'h2222, 1'b0);
      check_result("bp_first", 16'h1111, 16'h2222, 1'b0);
      held = bus.rsp_sum;
      for (int i = 0; i < 10; i++) begin
         bus.req_valid = 1'b1;
         bus.req_a     = 16'($urandom);
         bus.req_b     = 16'($urandom);
         bus.req_ci    = 1'($urandom);
         step();
         check("bp_sum_stable", bus.rsp_sum, held);
         check("bp_rsp_valid", bus.rsp_valid, 1);
         check("bp_req_ready", bus.req_ready, 0);
      end
      bus.req_a  = 16'h0F0F;
      bus.req_b  = 16'hF0F1;
      bus.req_ci = 1'b1;
      ack();
      check("bp_req_ready_release", bus.req_ready, 1);
      check("bp_rsp_valid_release", bus.rsp_valid, 0);
      issue(16'h0F0F, 16'hF0F1, 1'b1);
      check_result("bp_second", 16'h0F0F, 16'hF0F1, 1'b1);
      ack();

      // Reset during nibble 2.
      bus.req_valid = 1'b1;
      bus.req_a     = 16'hAAAA;
      bus.req_b     = 16'h5555;
      bus.req_ci    = 1'b0;
      step();
      bus.req_valid = 1'b0;
      step();
      step();
      check("mid_busy", busy, 1);
      check("mid_rca_a", rca_a, 4'hA);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_rsp_sum", bus.rsp_sum, 0);
      check("mid_rst_rsp_co_ovf", {bus.rsp_co, bus.rsp_ovf}, 0);
      check("mid_rst_req_ready", bus.req_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rca", {rca_a, rca_b, rca_ci}, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("mid_rst_req_ready_up", bus.req_ready, 1);
      saw = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.rsp_valid) saw++;
         step();
      end
      check("mid_rst_no_rsp", saw, 0);
      issue(16'h1357, 16'h2468, 1'b1);
      check_result("post_rst", 16'h1357, 16'h2468, 1'b1);
      ack();

      // Back-to-back random adds, rsp_ready tied high.
      tie_ready     = 1'b1;
      bus.rsp_ready = 1'b1;
      prev          = 0;
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         issue(ra, rb, rc);
         e = model(ra, rb, rc);
         check("rnd_sum", bus.rsp_sum, e[15:0]);
         check("rnd_co_ovf", {bus.rsp_co, bus.rsp_ovf}, {e[16], e[17]});
         check("rnd_latency", lat, N);
         if (i > 0) check("rnd_period", acc_cyc - prev, 6);
         prev = acc_cyc;
         step();
         check("rnd_rsp_valid_drop", bus.rsp_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
